bus_oe_arbiter: RTL and testbench
=================================

# bus_oe_arbiter

Round-robin arbiter that shares one tri-stated backplane bus between up to N octal buffer/line drivers. Each requester raises a request line. The block grants the bus to exactly one requester at a time and produces that requester's active-LOW output enable, which is wired to one enable pin of its driver. Between successive owners it inserts a programmable number of dead cycles with every enable HIGH, so two drivers never fight on the bus. An optional hold limit revokes a long-running grant when another requester is waiting.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Legal range is 2..8.
- `TURNAROUND`, default 1: dead cycles with all enables HIGH between owners. Legal range is 1..15. Zero is illegal.
- `MAX_HOLD`, default 0: maximum grant length in cycles while another request is pending. 0 means unlimited. Legal range is 0..255.

Ports:
- `clk`, in, 1: single clock. Everything is rising-edge.
- `rst_bar`, in, 1: asynchronous, active-LOW reset.
- `req`, in, `N_REQ`: request per requester. Level-sensitive and held while the bus is wanted.
- `grant`, out, `N_REQ`: one-hot or zero. Registered.
- `oe_bar`, out, `N_REQ`: active-LOW driver enables. Equals `~grant`.
- `owner`, out, `clog2(N_REQ)`: index of the current or most recent owner. Registered.
- `busy`, out, 1: HIGH when any grant is active or a turnaround is in progress.

## Operation
- Reset values, asynchronous: `grant`=0, `oe_bar`=all 1, `owner`=0, `busy`=0, state=IDLE, hold counter=0, turnaround counter=0.
- Priority pointer after reset: `last`=`N_REQ`-1, so requester 0 has the highest priority.
- Priority order: starts at `last`+1 and wraps modulo `N_REQ`. On each new grant to index k, set `last`=k.
- State IDLE:
  - If `req`≠0, go to GRANT. Set `grant` to the one-hot of the highest-priority requester, set `owner` to that index, and clear the hold counter.
  - If `req`=0, stay in IDLE.
- State GRANT:
  - If `req[owner]`=0, go to TURN. Clear `grant` and load the turnaround counter with `TURNAROUND`-1.
  - If `MAX_HOLD`>0, the hold counter equals `MAX_HOLD`-1, and some other request is set, go to TURN. This is preemption.
  - Otherwise, increment the hold counter, saturating at 255.
- State TURN:
  - All enables are HIGH and `busy`=1.
  - When the counter reaches 0: if `req`≠0, grant directly to the highest-priority requester, using the same actions as the IDLE path. If `req`=0, go to IDLE.
  - Otherwise, decrement the counter.
- A preempted owner that still holds `req` competes normally. Because `last` equals its index, it has the lowest priority.
- `grant` never changes from one nonzero value to a different nonzero value in a single edge. At least `TURNAROUND` cycles with `grant`=0 separate any two grants.
- Mid-operation reset forces every enable HIGH immediately, without waiting for a clock. It also restores the priority pointer to its reset value.

## Timing
- Grant latency from IDLE: `req` sampled HIGH at edge t, `grant` asserted after edge t. With `req` rising between edges t-1 and t, the owner drives from the cycle following edge t.
- Release: `req[owner]` sampled LOW at edge t, so `grant` goes to 0 after edge t.
- Next grant: the next grant appears after edge t+`TURNAROUND`.
- Preemption:
  - The owner keeps the bus for exactly `MAX_HOLD` cycles, counted from the first cycle `grant` is HIGH, provided a competitor was pending at the deciding edge.
  - If no competitor is pending, the hold counter saturates and no revoke occurs.
  - A competitor appearing later causes revocation at the next edge where the counter is ≥`MAX_HOLD`-1.
- `busy` is registered and aligned with the state: it is HIGH in GRANT and TURN, LOW in IDLE.
- All outputs come directly from flops. There is no combinational path from `req` to `grant` or `oe_bar`.

## Test plan
- **Reset:** assert `rst_bar`=0 mid-grant with `N_REQ`=4. Required: `oe_bar`=4'b1111 and `grant`=0 before the next clock edge. After release with `req`=0001, `grant`=0001 one edge later.
- **Single request:** `req`=0100 for 5 cycles, then 0. Required: `grant`=0100 and `owner`=2 for 5 cycles. Then `grant`=0, `busy` HIGH for 1 cycle (`TURNAROUND`=1), then IDLE.
- **Round-robin fairness:** `req`=1111 held constant, each owner drops `req` for one cycle after 3 cycles of grant. Required: grant order 0,1,2,3,0, each separated by exactly `TURNAROUND` zero-grant cycles.
- **Turnaround:** `TURNAROUND`=3, `req`=0011. Requester 0 releases at edge t. Required: `grant`=0 for 3 cycles, then `grant`=0010. Checker verifies one-hot-or-zero and no direct owner-to-owner switch.
- **Preemption:** `MAX_HOLD`=4, `req[0]` held HIGH, `req[1]` raised at cycle 1 of the grant. Required: `grant`=0001 for 4 cycles, 1 dead cycle, then `grant`=0010. Requester 0 is regranted only after requester 1 releases.
- **No competitor:** `MAX_HOLD`=4 with only `req[0]` HIGH for 300 cycles. Required: no revocation. Raising `req[3]` then causes revocation at the next edge.

Source files
------------

// File: rtl/bus_oe_arbiter_if.sv
// Shared backplane arbitration bundle: per-requester request lines in,
// registered grants, active-low driver enables, owner index and busy flag out.
interface bus_oe_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned OW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] oe_bar;
  logic [OW-1:0]    owner;
  logic             busy;

  modport master (output req, input grant, oe_bar, owner, busy);
  modport slave  (input req, output grant, oe_bar, owner, busy);
endinterface

// File: rtl/bus_oe_arbiter.sv
// Round-robin owner selection for a tri-stated bus, with dead cycles between
// owners and an optional hold limit that revokes a grant when others wait.
module bus_oe_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic           clk,
  input  logic           rst_bar,
  bus_oe_arbiter_if.slave bus
);
  localparam int unsigned OW        = $clog2(N_REQ);
  localparam int          N         = int'(N_REQ);
  localparam logic [3:0]  TURN_LOAD = 4'(TURNAROUND - 1);
  localparam logic [8:0]  HOLD_TH   = 9'(MAX_HOLD);
  localparam bit          HOLD_EN   = (MAX_HOLD > 0);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] oe_bar_q;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;
  logic             busy_q, busy_d;

  logic             pick_valid;
  logic [OW-1:0]    pick_idx;
  int               cand;
  logic             take;
  logic             other_req;
  logic             hold_expired;

  // First requester after the last owner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last_q) + i) % N;
      if (!pick_valid && bus.req[OW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(cand);
      end
    end
  end

  assign other_req    = |(bus.req & ~grant_q);
  // hold_q >= MAX_HOLD-1, written so it stays well-formed when MAX_HOLD is 0
  assign hold_expired = ({1'b0, hold_q} + 9'd2) > HOLD_TH;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    busy_d  = busy_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) take = 1'b1;
      end
      GRANT: begin
        if (!bus.req[owner_q] || (HOLD_EN && hold_expired && other_req)) begin
          state_d = TURN;
          grant_d = '0;
          turn_d  = TURN_LOAD;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q == 4'd0) begin
          if (pick_valid) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = N_REQ'(1) << pick_idx;
      owner_d = pick_idx;
      last_d  = pick_idx;
      hold_d  = 8'd0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      oe_bar_q <= '1;
      owner_q  <= '0;
      last_q   <= OW'(N_REQ - 1);
      hold_q   <= 8'd0;
      turn_q   <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      oe_bar_q <= ~grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.oe_bar = oe_bar_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_bus_oe_arbiter.sv
// Bench for bus_oe_arbiter: three instances (default, long turnaround,
// hold limit) share one request bus; one is checked per sequence.
module tb_bus_oe_arbiter;
  logic       clk;
  logic       rst_bar;
  logic [3:0] req;

  bus_oe_arbiter_if #(.N_REQ(4)) bif0 ();
  bus_oe_arbiter_if #(.N_REQ(4)) bif1 ();
  bus_oe_arbiter_if #(.N_REQ(4)) bif2 ();

  assign bif0.req = req;
  assign bif1.req = req;
  assign bif2.req = req;

  bus_oe_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_bar(rst_bar), .bus(bif0));
  bus_oe_arbiter #(.N_REQ(4), .TURNAROUND(3), .MAX_HOLD(0)) u_dut1 (
    .clk(clk), .rst_bar(rst_bar), .bus(bif1));
  bus_oe_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(4)) u_dut2 (
    .clk(clk), .rst_bar(rst_bar), .bus(bif2));

  logic [3:0] ga [3];
  logic [3:0] oa [3];
  logic [1:0] wa [3];
  logic       ba [3];

  assign ga[0] = bif0.grant;  assign oa[0] = bif0.oe_bar;
  assign wa[0] = bif0.owner;  assign ba[0] = bif0.busy;
  assign ga[1] = bif1.grant;  assign oa[1] = bif1.oe_bar;
  assign wa[1] = bif1.owner;  assign ba[1] = bif1.busy;
  assign ga[2] = bif2.grant;  assign oa[2] = bif2.oe_bar;
  assign wa[2] = bif2.owner;  assign ba[2] = bif2.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    int         dut;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  vec_t       tbl [$];
  exp_t       sb  [$];
  logic [3:0] prev_g [3];
  int         vectors;
  int         miscompares;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rs, input int d, input logic [3:0] r,
                     input logic [3:0] g, input logic [1:0] o, input logic b);
    vec_t v;
    v.do_rst = rs; v.dut = d; v.req = r; v.grant = g; v.owner = o; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input int d, input exp_t e, input string tag);
    logic [3:0] exp_oe;
    exp_oe = ~e.grant;
    chk({tag, " grant"},  32'(ga[d]), 32'(e.grant));
    chk({tag, " oe_bar"}, 32'(oa[d]), 32'(exp_oe));
    chk({tag, " owner"},  32'(wa[d]), 32'(e.owner));
    chk({tag, " busy"},   32'(ba[d]), 32'(e.busy));
    chk({tag, " onehot0"}, 32'($onehot0(ga[d])), 32'd1);
    if (prev_g[d] != 4'd0 && ga[d] != 4'd0)
      chk({tag, " direct_switch"}, 32'(ga[d]), 32'(prev_g[d]));
    prev_g[d] = ga[d];
  endtask

  // Drive one request pattern, expect the result after the next edge.
  task automatic step(input int d, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] o, input logic b, input string tag);
    exp_t e;
    e.grant = g; e.owner = o; e.busy = b;
    req = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(d, e, tag);
  endtask

  task automatic do_reset(input int d);
    exp_t e;
    req     = 4'b0000;
    rst_bar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_bar = 1'b1;
    for (int k = 0; k < 3; k++) prev_g[k] = 4'd0;
    e.grant = 4'b0000; e.owner = 2'd0; e.busy = 1'b0;
    check_outputs(d, e, "reset");
  endtask

  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    req         = 4'b0000;
    rst_bar     = 1'b0;
    for (int k = 0; k < 3; k++) prev_g[k] = 4'd0;

    // single request, TURNAROUND=1
    add(1, 0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    for (int k = 0; k < 4; k++) add(0, 0, 4'b0100, 4'b0100, 2'd2, 1'b1);
    add(0, 0, 4'b0000, 4'b0000, 2'd2, 1'b1);
    add(0, 0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    add(0, 0, 4'b0000, 4'b0000, 2'd2, 1'b0);
    // round robin: each owner drops its request after 3 grant cycles
    add(1, 0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(0, 0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(0, 0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(0, 0, 4'b1110, 4'b0000, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 0, 4'b1111, 4'b0010, 2'd1, 1'b1);
    add(0, 0, 4'b1101, 4'b0000, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 0, 4'b1111, 4'b0100, 2'd2, 1'b1);
    add(0, 0, 4'b1011, 4'b0000, 2'd2, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 0, 4'b1111, 4'b1000, 2'd3, 1'b1);
    add(0, 0, 4'b0111, 4'b0000, 2'd3, 1'b1);
    add(0, 0, 4'b1111, 4'b0001, 2'd0, 1'b1);
    add(0, 0, 4'b0000, 4'b0000, 2'd0, 1'b1);
    add(0, 0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // TURNAROUND=3
    add(1, 1, 4'b0011, 4'b0001, 2'd0, 1'b1);
    add(0, 1, 4'b0011, 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 1, 4'b0010, 4'b0000, 2'd0, 1'b1);
    add(0, 1, 4'b0010, 4'b0010, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 1, 4'b0000, 4'b0000, 2'd1, 1'b1);
    add(0, 1, 4'b0000, 4'b0000, 2'd1, 1'b0);
    // MAX_HOLD=4 preemption
    add(1, 2, 4'b0001, 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) add(0, 2, 4'b0011, 4'b0001, 2'd0, 1'b1);
    add(0, 2, 4'b0011, 4'b0000, 2'd0, 1'b1);
    add(0, 2, 4'b0011, 4'b0010, 2'd1, 1'b1);
    add(0, 2, 4'b0011, 4'b0010, 2'd1, 1'b1);
    add(0, 2, 4'b0001, 4'b0000, 2'd1, 1'b1);
    add(0, 2, 4'b0001, 4'b0001, 2'd0, 1'b1);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset(tbl[i].dut);
      step(tbl[i].dut, tbl[i].req, tbl[i].grant, tbl[i].owner, tbl[i].busy,
           $sformatf("vec%0d", i));
    end

    // async reset mid-grant must force enables high before any edge
    do_reset(0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "rst_a");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b1, "rst_b");
    step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, "rst_c");
    rst_bar = 1'b0;
    #2;
    e.grant = 4'b0000; e.owner = 2'd0; e.busy = 1'b0;
    check_outputs(0, e, "rst_async");
    #2;
    rst_bar = 1'b1;
    // pointer back at reset value: requester 0 wins over requester 1
    step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, "rst_ptr");

    // no competitor: hold counter saturates without revoking
    do_reset(2);
    for (int k = 0; k < 300; k++)
      step(2, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("solo%0d", k));
    step(2, 4'b1001, 4'b0000, 2'd0, 1'b1, "late_revoke");
    step(2, 4'b1001, 4'b1000, 2'd3, 1'b1, "late_grant");
    step(2, 4'b0000, 4'b0000, 2'd3, 1'b1, "late_rel");
    step(2, 4'b0000, 4'b0000, 2'd3, 1'b0, "late_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
